// File: rtl/ks_pipelined_adder_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder/subtractor.
// One prefix lane carries the raw propagate, the group generate and the group propagate.
package ks_pkg;

  localparam int KS_MIN_WIDTH = 2;

  typedef struct packed {
    logic p;
    logic g;
    logic pp;
  } ks_lane_t;

  function automatic int ks_levels(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ks_pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder.
// The slave modport is the adder's view, the master modport is the producer/consumer's view.
interface ks_pipelined_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/ks_pipelined_adder_prefix.sv
// One combinational Kogge-Stone prefix level: black cells at distance DIST, buffers below it.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  ks_lane_t [WIDTH-1:0] lanes_in,
  output ks_lane_t [WIDTH-1:0] lanes_out
);

  always_comb begin
    lanes_out = lanes_in;
    for (int i = DIST; i < WIDTH; i++) begin
      lanes_out[i].g  = lanes_in[i].g | (lanes_in[i].pp & lanes_in[i-DIST].g);
      lanes_out[i].pp = lanes_in[i].pp & lanes_in[i-DIST].pp;
    end
  end

endmodule

// File: rtl/ks_pipelined_adder.sv
// Pipelined Kogge-Stone adder/subtractor: PG stage, LEVELS prefix stages and a sum stage,
// each registered, with a collapsing valid/ready chain giving one result per cycle.
module ks_pipelined_adder
  import ks_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  ks_pipelined_adder_if.slave bus
);

  localparam int LEVELS = ks_levels(WIDTH);
  localparam int DEPTH  = LEVELS + 2;
  localparam int OUT    = DEPTH - 1;

  if (WIDTH < KS_MIN_WIDTH) begin : g_width_check
    $error("ks_pipelined_adder: WIDTH must be at least KS_MIN_WIDTH");
  end

  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     load;
  logic [WIDTH-1:0]     b_eff;
  logic [WIDTH-1:0]     p0;
  logic [WIDTH-1:0]     g0;
  logic                 c0;
  ks_lane_t [WIDTH-1:0] lane0_d;
  ks_lane_t [WIDTH-1:0] stage_d [1:LEVELS];
  ks_lane_t [WIDTH-1:0] lane_q  [0:LEVELS];
  logic                 c_q     [0:LEVELS];
  logic [WIDTH-1:0]     p_fin;
  logic [WIDTH-1:0]     g_fin;
  logic [WIDTH-1:0]     sum_d;
  logic [WIDTH-1:0]     out_sum_q;
  logic                 out_cout_q;
  logic                 out_ovf_q;

  // A stage may load when any stage at or after it has a hole, or the result is being popped.
  always_comb begin
    logic gap;
    gap = bus.out_ready;
    load = '0;
    for (int s = OUT; s >= 0; s--) begin
      gap     = gap | !valid_q[s];
      load[s] = gap;
    end
  end

  assign b_eff = bus.in_b ^ {WIDTH{bus.in_sub}};
  assign c0    = bus.in_cin ^ bus.in_sub;
  assign p0    = bus.in_a ^ b_eff;
  assign g0    = bus.in_a & b_eff;

  // Carry-in is folded into bit 0 so the prefix tree needs no separate carry lane.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      lane0_d[i].p  = p0[i];
      lane0_d[i].g  = g0[i];
      lane0_d[i].pp = p0[i];
    end
    lane0_d[0].g = g0[0] | (p0[0] & c0);
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    ks_prefix_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << (k - 1))
    ) u_level (
      .lanes_in  (lane_q[k-1]),
      .lanes_out (stage_d[k])
    );
  end

  always_ff @(posedge clk) begin
    if (load[0] && bus.in_valid) begin
      lane_q[0] <= lane0_d;
      c_q[0]    <= c0;
    end
    for (int s = 1; s <= LEVELS; s++) begin
      if (load[s] && valid_q[s-1]) begin
        lane_q[s] <= stage_d[s];
        c_q[s]    <= c_q[s-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      p_fin[i] = lane_q[LEVELS][i].p;
      g_fin[i] = lane_q[LEVELS][i].g;
    end
  end

  assign sum_d = p_fin ^ {g_fin[WIDTH-2:0], c_q[LEVELS]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      if (load[0]) valid_q[0] <= bus.in_valid;
      for (int s = 1; s < DEPTH; s++) begin
        if (load[s]) valid_q[s] <= valid_q[s-1];
      end
      if (load[OUT] && valid_q[OUT-1]) begin
        out_sum_q  <= sum_d;
        out_cout_q <= g_fin[WIDTH-1];
        out_ovf_q  <= g_fin[WIDTH-1] ^ g_fin[WIDTH-2];
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid_q[OUT];
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_ks_pipelined_adder.sv
// Directed vectors, backpressure, mid-stream reset and a random scoreboard run for the
// 16-bit pipelined Kogge-Stone adder/subtractor.
module tb_ks_pipelined_adder;

  localparam int W   = 16;
  localparam int LAT = 5;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   pushes;
  int   pops;
  exp_t exp_q[$];
  vec_t vecs[10];

  ks_pipelined_adder_if #(.WIDTH(W)) bus ();

  ks_pipelined_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Independent reference: wide addition, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    exp_t         e;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin ^ sub};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (e.sum[W-1] != a[W-1]);
    return e;
  endfunction

  // Caller drives inputs after a negedge; this records handshakes and moves to the next edge.
  task automatic step();
    exp_t e;
    #1;
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
      pushes++;
    end
    if (bus.out_valid && bus.out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        check_output("unexpected_output", 32'(bus.out_sum), 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check_output("stream_result", {15'd0, bus.out_ovf, bus.out_cout, bus.out_sum},
                     {15'd0, e.ovf, e.cout, e.sum});
      end
    end
    @(posedge clk);
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    bus.in_cin   = v.cin;
    bus.in_sub   = v.sub;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) lat = n;
    end
    check_output({tag, "_latency"}, 32'(lat), 32'(LAT));
    check_output({tag, "_sum"}, 32'(bus.out_sum), 32'(v.sum));
    check_output({tag, "_cout"}, 32'(bus.out_cout), 32'(v.cout));
    check_output({tag, "_ovf"}, 32'(bus.out_ovf), 32'(v.ovf));
    @(posedge clk);
  endtask

  initial begin
    int cyc;
    int stalls;
    int in_cnt;
    int out_cnt;
    tests  = 0;
    fails  = 0;
    pushes = 0;
    pops   = 0;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[9] = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("reset_out_sum", 32'(bus.out_sum), 32'd0);
    check_output("reset_out_cout", 32'(bus.out_cout), 32'd0);
    check_output("reset_out_ovf", 32'(bus.out_ovf), 32'd0);
    check_output("reset_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 10; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: fill all six stages, then pop and push in the same cycle.
    exp_q.delete();
    pushes = 0;
    pops   = 0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (pushes < 8);
      bus.in_a     = 16'(pushes);
      bus.in_b     = 16'(pushes);
      bus.in_cin   = 1'b0;
      bus.in_sub   = 1'b0;
      step();
      @(negedge clk);
    end
    #1;
    check_output("full_accepted", 32'(pushes), 32'd6);
    check_output("full_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("full_out_valid", 32'(bus.out_valid), 32'd1);
    check_output("full_out_sum_held", 32'(bus.out_sum), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check_output("pop_push_in_ready", 32'(bus.in_ready), 32'd1);
    cyc = 0;
    while ((pushes < 8 || exp_q.size() != 0) && cyc < 40) begin
      bus.in_valid = (pushes < 8);
      bus.in_a     = 16'(pushes);
      bus.in_b     = 16'(pushes);
      step();
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_output("bp_pops", 32'(pops), 32'd8);
    check_output("bp_drained", 32'(exp_q.size()), 32'd0);

    // Mid-stream reset: three beats in flight, reset while the first result is showing.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'(16'h0100 + i);
      bus.in_b     = 16'h0011;
      step();
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_output("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    stalls = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) stalls++;
    end
    check_output("no_stale_result", 32'(stalls), 32'd0);
    apply_stimulus(vecs[1], "post_reset");

    // Sustained throughput with both sides always ready.
    exp_q.delete();
    in_cnt  = 0;
    out_cnt = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 16'($urandom());
      bus.in_b     = 16'($urandom());
      bus.in_cin   = 1'($urandom());
      bus.in_sub   = 1'($urandom());
      if (c >= 20) begin
        #1;
        if (bus.in_valid && bus.in_ready) in_cnt++;
        if (bus.out_valid && bus.out_ready) out_cnt++;
        #(-1 + 1);
      end
      step();
      @(negedge clk);
    end
    check_output("throughput_in", 32'(in_cnt), 32'd40);
    check_output("throughput_out", 32'(out_cnt), 32'd40);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step();
      @(negedge clk);
      cyc++;
    end
    check_output("throughput_drained", 32'(exp_q.size()), 32'd0);

    // Random traffic with random backpressure.
    pushes = 0;
    cyc    = 0;
    while (pushes < 10000 && cyc < 60000) begin
      bus.in_valid  = 1'($urandom());
      bus.in_a      = 16'($urandom());
      bus.in_b      = 16'($urandom());
      bus.in_cin    = 1'($urandom());
      bus.in_sub    = 1'($urandom());
      bus.out_ready = 1'($urandom());
      step();
      @(negedge clk);
      cyc++;
    end
    check_output("random_pushes", 32'(pushes), 32'd10000);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step();
      @(negedge clk);
      cyc++;
    end
    check_output("random_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    check_output("random_no_extra", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
